alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  instruction present on in_instr.
REQ-005 in_ready  output  1  instruction accepted this cycle; equals ~stall.
REQ-006 in_instr  input  14  [13:10] op, [9] wc (use carry flag as Cin), [8:6] rd, [5:3] rs1, [2:0] rs2.
REQ-007 stall  input  1  freezes the issue register and suppresses writeback.
REQ-008 alu_cont  output  4  registered op to the 8-bit ALU.
REQ-009 alu_a, alu_b  output  8 each  registered operands to the ALU.
REQ-010 alu_cin  output  1  registered carry/borrow-in to the ALU.
REQ-011 alu_x  input  8  ALU result, combinational from the registered outputs.
REQ-012 alu_zero, alu_cout  input  1 each  ALU zero and carry/borrow-out.
REQ-013 flag_c, flag_z  output  1 each  architectural carry and zero flags.
REQ-014 wb_valid  output  1  one-cycle pulse after each register writeback.
REQ-015 wb_rd, wb_data  output  3, 8  destination and value of that writeback.
REQ-016 dbg_addr, dbg_data  input 3, output 8  combinational register-file read port.

Function
REQ-017 The register file SHALL hold 8 x 8-bit registers; r0 reads 0, and writes to it are discarded.
REQ-018 Issue register (iss_valid, iss_rd, iss_wc, outputs) SHALL load on every edge with stall=0; iss_valid <= in_valid.
REQ-019 With stall=1 the issue register, flags and register file SHALL hold; in_valid is ignored.
REQ-020 Writeback edge: iss_valid=1 and stall=0; rf[iss_rd] <= alu_x, flag_z <= alu_zero, flag_c <= alu_cout.
REQ-021 Ops 0011 and 1111 are reserved: they SHALL issue with alu_cont unchanged and iss_valid=1 but perform no register, flag or wb_valid update.
REQ-022 alu_cin SHALL be flag_c when wc=1, else 0.
REQ-023 Forwarding: on a writeback edge, any operand of the accepted instruction with rs == iss_rd (rs!=0) SHALL take alu_x, not the stale rf value.
REQ-024 Carry forwarding: wc=1 on a writeback edge SHALL take alu_cout as Cin; zero flag is not an input to issue.
REQ-025 Latency: accept edge N -> ALU inputs valid in cycle N+1 -> writeback at edge N+1 (if not stalled) -> wb_valid high in cycle N+2.
REQ-026 Back-to-back dependent instructions SHALL issue every cycle with no bubble.
REQ-027 dbg_data SHALL reflect rf after the last edge (no forwarding).
REQ-028 An empty issue slot (iss_valid=0) SHALL drive alu_cont=0000, alu_a=alu_b=0, alu_cin=0.

Reset
REQ-029 rst SHALL clear rf, flag_c, flag_z, iss_valid, wb_valid, wb_rd, wb_data and all ALU-facing outputs to 0 immediately, independent of clk.
REQ-030 Reset mid-operation SHALL discard the in-flight issue without writeback; the first accept after release behaves as after power-up.

Structure
REQ-031 Shared package alu_pkg SHALL hold op encodings (AND, OR, ADD, SLT-reserved, ANDN, ORN, SUB, SLT, NANDA, NORA, RSUB, SGT, NOR, NAND, NADD2, reserved) and instr field offsets.
REQ-032 Sub-module regfile_8x8 (two read ports, one write port, debug read port) is the single natural split; forwarding muxes stay in alu_issue_stage.
REQ-033 The ALU SHALL be instantiated only in the testbench.

Verification
REQ-034 Reset, then ADD r1=r0+r0 -> wb_data=0x00, flag_z=1, flag_c=0, wb_valid one cycle.
REQ-035 Preload r1=0xF0, r2=0x20 via ORs; ADD r3=r1+r2 -> wb_data=0x10, flag_c=1; next ADD wc=1 r4=r0+r0 -> wb_data=0x01.
REQ-036 Back-to-back ADD r1=r2+r2 then SUB r5=r1-r2 with r2=0x05 -> r1=0x0A, r5=0x05, no bubble.
REQ-037 Stall=1 for 3 cycles with a valid issue -> alu_* outputs stable, single writeback after release.
REQ-038 Op 1111 to r6 -> r6, flags unchanged, wb_valid stays 0; write to r0 -> dbg_data(r0)=0x00.
REQ-039 Assert rst mid-issue -> all outputs 0 within the same cycle, no writeback.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: instruction field layout,
// ALU op encodings, the decoded instruction record and small helpers.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;
  localparam int OP_W     = 4;
  localparam int INSTR_W  = 14;

  // Instruction word layout: [13:10] op, [9] wc, [8:6] rd, [5:3] rs1, [2:0] rs2
  localparam int OP_LSB  = 10;
  localparam int WC_BIT  = 9;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_SLTR  = 4'h3,  // reserved slot
    OP_ANDN  = 4'h4,
    OP_ORN   = 4'h5,
    OP_SUB   = 4'h6,
    OP_SLT   = 4'h7,
    OP_NANDA = 4'h8,
    OP_NORA  = 4'h9,
    OP_RSUB  = 4'hA,
    OP_SGT   = 4'hB,
    OP_NOR   = 4'hC,
    OP_NAND  = 4'hD,
    OP_NADD2 = 4'hE,
    OP_RSV15 = 4'hF   // reserved slot
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic              wc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op  = alu_op_e'(raw[OP_LSB +: OP_W]);
    d.wc  = raw[WC_BIT];
    d.rd  = raw[RD_LSB +: REG_AW];
    d.rs1 = raw[RS1_LSB +: REG_AW];
    d.rs2 = raw[RS2_LSB +: REG_AW];
    return d;
  endfunction

  // Build a raw instruction word from its fields.
  function automatic logic [INSTR_W-1:0] encode(input alu_op_e op, input logic wc,
                                                input logic [REG_AW-1:0] rd,
                                                input logic [REG_AW-1:0] rs1,
                                                input logic [REG_AW-1:0] rs2);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: OP_W]    = op;
    w[WC_BIT]            = wc;
    w[RD_LSB +: REG_AW]  = rd;
    w[RS1_LSB +: REG_AW] = rs1;
    w[RS2_LSB +: REG_AW] = rs2;
    return w;
  endfunction

  // Reserved ops travel down the pipe but never commit anything.
  function automatic logic is_reserved(input alu_op_e op);
    return (op == OP_SLTR) || (op == OP_RSV15);
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8 x 8-bit register file: two operand read ports, one write port and a
// debug read port. r0 is hard-wired to zero; writes to it are dropped.
module regfile_8x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Register storage with async clear; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the array as of the last edge; r0 forced to zero explicitly.
  assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of an external 8-bit ALU. Holds the architectural
// register file and flags, registers one instruction's operands toward the
// ALU and commits the ALU result on the following edge. Results and carry
// being committed on an edge are forwarded to the instruction accepted on
// that same edge, so dependent instructions issue back-to-back.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               stall,
  output logic [OP_W-1:0]    alu_cont,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_x,
  input  logic               alu_zero,
  input  logic               alu_cout,
  output logic               flag_c,
  output logic               flag_z,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  instr_t            dec;
  logic              iss_valid;
  logic              iss_rsv;
  logic [REG_AW-1:0] iss_rd;
  logic              wb_fire;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              cin_next;

  assign dec      = decode(in_instr);
  assign in_ready = ~stall;

  // A commit happens on any unstalled edge while a non-reserved op sits in the slot.
  assign wb_fire = iss_valid & ~iss_rsv & ~stall;

  regfile_8x8 u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_fire),
    .waddr    (iss_rd),
    .wdata    (alu_x),
    .raddr_a  (dec.rs1),
    .rdata_a  (rf_a),
    .raddr_b  (dec.rs2),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // The register file only updates at the edge, so a source matching the
  // destination being committed right now must take the live ALU result.
  assign fwd_a  = wb_fire && (dec.rs1 != '0) && (dec.rs1 == iss_rd);
  assign fwd_b  = wb_fire && (dec.rs2 != '0) && (dec.rs2 == iss_rd);
  assign opnd_a = fwd_a ? alu_x : rf_a;
  assign opnd_b = fwd_b ? alu_x : rf_b;

  // Same reasoning for carry: the flag committed on this edge is alu_cout.
  assign cin_next = dec.wc & (wb_fire ? alu_cout : flag_c);

  // Issue register: reloads on every unstalled edge, empty slot drives zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_rsv   <= 1'b0;
      iss_rd    <= '0;
      alu_cont  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
    end else if (!stall) begin
      iss_valid <= in_valid;
      if (in_valid) begin
        iss_rsv  <= is_reserved(dec.op);
        iss_rd   <= dec.rd;
        alu_cont <= dec.op;
        alu_a    <= opnd_a;
        alu_b    <= opnd_b;
        alu_cin  <= cin_next;
      end else begin
        iss_rsv  <= 1'b0;
        iss_rd   <= '0;
        alu_cont <= '0;
        alu_a    <= '0;
        alu_b    <= '0;
        alu_cin  <= 1'b0;
      end
    end
  end

  // Architectural flags follow the ALU on each commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (wb_fire) begin
      flag_c <= alu_cout;
      flag_z <= alu_zero;
    end
  end

  // Writeback report: one-cycle pulse, destination and value held until the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= wb_fire;
      if (wb_fire) begin
        wb_rd   <= iss_rd;
        wb_data <= alu_x;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 8-bit ALU closing
// the loop. A table of dependent instructions runs back-to-back, followed
// by hand-written stall and mid-issue reset sequences.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               stall;
  logic [OP_W-1:0]    alu_cont;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic               alu_cin;
  logic [DATA_W-1:0]  alu_x;
  logic               alu_zero;
  logic               alu_cout;
  logic               flag_c;
  logic               flag_z;
  logic               wb_valid;
  logic [REG_AW-1:0]  wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic [REG_AW-1:0]  dbg_addr;
  logic [DATA_W-1:0]  dbg_data;

  int n_tests;
  int n_fail;

  alu_issue_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .stall    (stall),
    .alu_cont (alu_cont),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_x    (alu_x),
    .alu_zero (alu_zero),
    .alu_cout (alu_cout),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; reserved/unmodelled ops give a nonzero result with carry
  // set so a wrongful commit would disturb registers and flags.
  logic [8:0] alu_t;
  always_comb begin
    alu_t    = '0;
    alu_x    = '0;
    alu_cout = 1'b0;
    case (alu_cont)
      OP_AND: alu_x = alu_a & alu_b;
      OP_OR:  alu_x = alu_a | alu_b;
      OP_NOR: alu_x = ~(alu_a | alu_b);
      OP_NAND: alu_x = ~(alu_a & alu_b);
      OP_ADD: begin
        alu_t    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_x    = alu_t[7:0];
        alu_cout = alu_t[8];
      end
      OP_SUB: begin
        alu_t    = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
        alu_x    = alu_t[7:0];
        alu_cout = alu_t[8];
      end
      default: begin
        alu_x    = alu_a ^ alu_b;
        alu_cout = 1'b1;
      end
    endcase
  end
  assign alu_zero = (alu_x == 8'h00);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic               exp_wb;
    logic [DATA_W-1:0]  exp_data;
    logic               exp_c;
    logic               exp_z;
  } vec_t;

  function automatic vec_t mkv(input alu_op_e op, input logic wc, input logic [2:0] rd,
                               input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic wb, input logic [7:0] d,
                               input logic c, input logic z);
    vec_t v;
    v.instr    = encode(op, wc, rd, rs1, rs2);
    v.exp_wb   = wb;
    v.exp_data = d;
    v.exp_c    = c;
    v.exp_z    = z;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t rows [NV];
  logic [7:0] exp_regs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    stall    = 1'b0;
    dbg_addr = '0;

    rows[0]  = mkv(OP_ADD,   1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1);
    rows[1]  = mkv(OP_NOR,   1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b0);
    rows[2]  = mkv(OP_ADD,   1'b0, 3'd1, 3'd1, 3'd1, 1'b1, 8'hFE, 1'b1, 1'b0);
    rows[3]  = mkv(OP_ADD,   1'b0, 3'd1, 3'd1, 3'd1, 1'b1, 8'hFC, 1'b1, 1'b0);
    rows[4]  = mkv(OP_ADD,   1'b0, 3'd1, 3'd1, 3'd1, 1'b1, 8'hF8, 1'b1, 1'b0);
    rows[5]  = mkv(OP_ADD,   1'b0, 3'd1, 3'd1, 3'd1, 1'b1, 8'hF0, 1'b1, 1'b0);
    rows[6]  = mkv(OP_SUB,   1'b0, 3'd2, 3'd0, 3'd1, 1'b1, 8'h10, 1'b1, 1'b0);
    rows[7]  = mkv(OP_ADD,   1'b0, 3'd2, 3'd2, 3'd2, 1'b1, 8'h20, 1'b0, 1'b0);
    rows[8]  = mkv(OP_ADD,   1'b0, 3'd3, 3'd1, 3'd2, 1'b1, 8'h10, 1'b1, 1'b0);
    rows[9]  = mkv(OP_ADD,   1'b1, 3'd4, 3'd0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0);
    rows[10] = mkv(OP_OR,    1'b0, 3'd6, 3'd1, 3'd2, 1'b1, 8'hF0, 1'b0, 1'b0);
    rows[11] = mkv(OP_ADD,   1'b0, 3'd7, 3'd4, 3'd4, 1'b1, 8'h02, 1'b0, 1'b0);
    rows[12] = mkv(OP_ADD,   1'b0, 3'd7, 3'd7, 3'd7, 1'b1, 8'h04, 1'b0, 1'b0);
    rows[13] = mkv(OP_ADD,   1'b0, 3'd2, 3'd7, 3'd4, 1'b1, 8'h05, 1'b0, 1'b0);
    rows[14] = mkv(OP_ADD,   1'b0, 3'd1, 3'd2, 3'd2, 1'b1, 8'h0A, 1'b0, 1'b0);
    rows[15] = mkv(OP_SUB,   1'b0, 3'd5, 3'd1, 3'd2, 1'b1, 8'h05, 1'b0, 1'b0);
    rows[16] = mkv(OP_SUB,   1'b0, 3'd0, 3'd2, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1);
    rows[17] = mkv(OP_RSV15, 1'b0, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1);
    rows[18] = mkv(OP_SLTR,  1'b1, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1);

    exp_regs = '{8'h00, 8'h0A, 8'h05, 8'h10, 8'h01, 8'h05, 8'hF0, 8'h04};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst alu_cont", 32'(alu_cont), 32'(0));
    chk("rst alu_a",    32'(alu_a),    32'(0));
    chk("rst alu_b",    32'(alu_b),    32'(0));
    chk("rst alu_cin",  32'(alu_cin),  32'(0));
    chk("rst flag_c",   32'(flag_c),   32'(0));
    chk("rst flag_z",   32'(flag_z),   32'(0));
    chk("rst wb_valid", 32'(wb_valid), 32'(0));
    chk("rst wb_data",  32'(wb_data),  32'(0));
    chk("rst in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;

    // Back-to-back table: after row k's accept edge, row k-1 has committed
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        in_valid = 1'b1;
        in_instr = rows[k].instr;
      end else begin
        in_valid = 1'b0;
        in_instr = '0;
      end
      tick();
      if (k < NV) begin
        chk($sformatf("row%0d alu_cont", k), 32'(alu_cont), 32'(rows[k].instr[13:10]));
      end else begin
        chk("empty alu_cont", 32'(alu_cont), 32'(0));
        chk("empty alu_a",    32'(alu_a),    32'(0));
        chk("empty alu_b",    32'(alu_b),    32'(0));
        chk("empty alu_cin",  32'(alu_cin),  32'(0));
      end
      if (k > 0) begin
        chk($sformatf("row%0d wb_valid", k-1), 32'(wb_valid), 32'(rows[k-1].exp_wb));
        if (rows[k-1].exp_wb) begin
          chk($sformatf("row%0d wb_rd", k-1),   32'(wb_rd),   32'(rows[k-1].instr[8:6]));
          chk($sformatf("row%0d wb_data", k-1), 32'(wb_data), 32'(rows[k-1].exp_data));
        end
        chk($sformatf("row%0d flag_c", k-1), 32'(flag_c), 32'(rows[k-1].exp_c));
        chk($sformatf("row%0d flag_z", k-1), 32'(flag_z), 32'(rows[k-1].exp_z));
      end
    end

    // Register file contents after the table
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      chk($sformatf("dbg r%0d", r), 32'(dbg_data), 32'(exp_regs[r]));
    end

    // Stall for three cycles with ADD r3=r4+r4 in the slot
    dbg_addr = 3'd3;
    in_valid = 1'b1;
    in_instr = encode(OP_ADD, 1'b0, 3'd3, 3'd4, 3'd4);
    tick();
    chk("stall accept a", 32'(alu_a), 32'(8'h01));
    stall    = 1'b1;
    in_instr = encode(OP_NOR, 1'b0, 3'd3, 3'd0, 3'd0);
    #1;
    chk("stall in_ready", 32'(in_ready), 32'(0));
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall%0d alu_cont", s), 32'(alu_cont), 32'(OP_ADD));
      chk($sformatf("stall%0d alu_a", s),    32'(alu_a),    32'(8'h01));
      chk($sformatf("stall%0d alu_b", s),    32'(alu_b),    32'(8'h01));
      chk($sformatf("stall%0d wb_valid", s), 32'(wb_valid), 32'(0));
      chk($sformatf("stall%0d flag_z", s),   32'(flag_z),   32'(1));
      chk($sformatf("stall%0d dbg r3", s),   32'(dbg_data), 32'(8'h10));
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("release wb_valid", 32'(wb_valid), 32'(1));
    chk("release wb_rd",    32'(wb_rd),    32'(3));
    chk("release wb_data",  32'(wb_data),  32'(8'h02));
    chk("release flag_z",   32'(flag_z),   32'(0));
    chk("release dbg r3",   32'(dbg_data), 32'(8'h02));
    chk("release alu_cont", 32'(alu_cont), 32'(0));
    tick();
    chk("release pulse end", 32'(wb_valid), 32'(0));

    // Reset while an instruction is in flight
    dbg_addr = 3'd7;
    in_valid = 1'b1;
    in_instr = encode(OP_SUB, 1'b0, 3'd7, 3'd0, 3'd4);
    tick();
    in_instr = encode(OP_ADD, 1'b0, 3'd5, 3'd4, 3'd4);
    tick();
    in_valid = 1'b0;
    in_instr = '0;
    chk("pre-rst wb_data", 32'(wb_data),  32'(8'hFF));
    chk("pre-rst flag_c",  32'(flag_c),   32'(1));
    chk("pre-rst alu_a",   32'(alu_a),    32'(8'h01));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst alu_cont", 32'(alu_cont), 32'(0));
    chk("midrst alu_a",    32'(alu_a),    32'(0));
    chk("midrst alu_b",    32'(alu_b),    32'(0));
    chk("midrst wb_valid", 32'(wb_valid), 32'(0));
    chk("midrst wb_rd",    32'(wb_rd),    32'(0));
    chk("midrst wb_data",  32'(wb_data),  32'(0));
    chk("midrst flag_c",   32'(flag_c),   32'(0));
    chk("midrst dbg r7",   32'(dbg_data), 32'(0));
    tick();
    rst = 1'b0;
    dbg_addr = 3'd5;
    tick();
    chk("postrst wb_valid", 32'(wb_valid), 32'(0));
    chk("postrst dbg r5",   32'(dbg_data), 32'(0));

    // First instruction after release behaves as after power-up
    dbg_addr = 3'd1;
    in_valid = 1'b1;
    in_instr = encode(OP_NOR, 1'b0, 3'd1, 3'd0, 3'd0);
    tick();
    in_valid = 1'b0;
    in_instr = '0;
    chk("post accept alu_cont", 32'(alu_cont), 32'(OP_NOR));
    tick();
    chk("post wb_valid", 32'(wb_valid), 32'(1));
    chk("post wb_rd",    32'(wb_rd),    32'(1));
    chk("post wb_data",  32'(wb_data),  32'(8'hFF));
    chk("post dbg r1",   32'(dbg_data), 32'(8'hFF));
    tick();
    chk("post pulse end", 32'(wb_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
